// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply or restoring
// divide on operand magnitudes, with sign fix-up and RISC-V divide special cases.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [2:0]       f3_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         f3_q, f3_d;
  logic               a_neg_q, a_neg_d;
  logic               b_neg_q, b_neg_d;
  logic [WIDTH-1:0]   a_mag_q, a_mag_d;
  logic [WIDTH-1:0]   b_mag_q, b_mag_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   result_q, result_d;

  // Operand decode on the raw inputs, used only in the launch cycle
  logic             is_div_in;
  logic             a_sgn_in, b_sgn_in;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;
  logic             div_by_zero, div_ovf;

  assign is_div_in = f3_i[2];
  assign a_sgn_in  = a_i[WIDTH-1] & ((f3_i == F3_MULH) | (f3_i == F3_MULHSU) |
                                     (f3_i == F3_DIV)  | (f3_i == F3_REM));
  assign b_sgn_in  = b_i[WIDTH-1] & ((f3_i == F3_MULH) | (f3_i == F3_DIV) |
                                     (f3_i == F3_REM));
  assign a_mag_in  = a_sgn_in ? -a_i : a_i;
  assign b_mag_in  = b_sgn_in ? -b_i : b_i;
  assign div_by_zero = is_div_in && (b_i == '0);
  assign div_ovf     = ((f3_i == F3_DIV) || (f3_i == F3_REM)) &&
                       (a_i == MIN_NEG) && (b_i == '1);

  // Multiply: acc = {partial product high, remaining multiplier bits}
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   (acc_q[0] ? {1'b0, a_mag_q} : '0);

  // Divide: acc low half shifts dividend out of the MSB and quotient into the LSB
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] trial;
  assign rem_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
  assign trial     = {1'b0, rem_shift} - {2'b00, b_mag_q};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_sel;
  assign prod_fix = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
  assign quo_fix  = (a_neg_q ^ b_neg_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = a_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  always_comb begin
    fix_sel = prod_fix[2*WIDTH-1:WIDTH];
    if (f3_q == F3_MUL)     fix_sel = prod_fix[WIDTH-1:0];
    else if (f3_q[2])       fix_sel = f3_q[1] ? rem_fix : quo_fix;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    result_d = result_q;

    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            f3_d    = f3_i;
            a_neg_d = a_sgn_in;
            b_neg_d = b_sgn_in;
            a_mag_d = a_mag_in;
            b_mag_d = b_mag_in;
            cnt_d   = '0;
            rem_d   = '0;
            acc_d   = {{WIDTH{1'b0}}, (is_div_in ? a_mag_in : b_mag_in)};
            if (div_by_zero) begin
              result_d = f3_i[1] ? a_i : '1;
              state_d  = S_DONE;
            end else if (div_ovf) begin
              result_d = f3_i[1] ? '0 : MIN_NEG;
              state_d  = S_DONE;
            end else begin
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          if (f3_q[2]) begin
            if (!trial[WIDTH+1]) begin
              rem_d = trial[WIDTH:0];
              acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_d = rem_shift;
              acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_FIX;
        end
        S_FIX: begin
          result_d = fix_sel;
          state_d  = S_DONE;
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      a_mag_q  <= a_mag_d;
      b_mag_q  <= b_mag_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q == S_CALC) || (state_q == S_FIX);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: cycle-level reference model checked every cycle,
// plus directed runs with hand-computed results and latencies.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  f3;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
    .f3_i(f3), .a_i(a), .b_i(b),
    .busy_o(busy), .done_o(done), .result_o(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] x,
                                             input logic [31:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    case (op)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        p = sx / sy; return p[31:0];
      end
      3'd5: begin
        if (y == 0) return 32'hFFFF_FFFF;
        p = ux / uy; return p[31:0];
      end
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        p = sx % sy; return p[31:0];
      end
      default: begin
        if (y == 0) return x;
        p = ux % uy; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] x,
                                    input logic [31:0] y);
    return op[2] && ((y == 0) ||
           (!op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
  endfunction

  // Model: an accepted op runs m_len cycles (34 normal, 1 special), cycle 1 being
  // the one right after the launch edge; done in the last, busy in 1..33 if normal.
  bit          m_active = 1'b0;
  int          m_t = 0, m_len = 0;
  logic [31:0] m_pend = '0, m_res = '0;
  bit          cmp_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_res    = '0;
    end else if (m_active && m_t == m_len) begin
      m_active = 1'b0;
    end else if (flush) begin
      m_active = 1'b0;
    end else if (m_active) begin
      m_t++;
      if (m_t == m_len) m_res = m_pend;
    end else if (start) begin
      m_active = 1'b1;
      m_t      = 1;
      m_pend   = ref_result(f3, a, b);
      m_len    = is_special(f3, a, b) ? 1 : 34;
      if (m_len == 1) m_res = m_pend;
    end
    cmp_en = 1'b1;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model busy", {31'd0, busy}, {31'd0, (m_active && m_len == 34 && m_t <= 33)});
      check("model done", {31'd0, done}, {31'd0, (m_active && m_t == m_len)});
      check("model result", result, m_res);
    end
  end

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_res, input int exp_lat);
    int lat, nbusy;
    @(posedge clk); #1;
    f3 = op; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; f3 = 3'($urandom);
    lat = 1;
    nbusy = 0;
    while (!done && lat < 60) begin
      if (busy) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " busy cycles"}, 32'(nbusy), (exp_lat == 34) ? 32'd33 : 32'd0);
    check({name, " result"}, result, exp_res);
    @(posedge clk); #1;
    check({name, " done pulse width"}, {31'd0, done}, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int ndone;
    rst = 1'b1; start = 1'b0; flush = 1'b0; f3 = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    rst = 1'b0;

    run_op("MUL 7*-3",       3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run_op("MULHU -1*-1",    3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op("MULH -1*-1",     3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 34);
    run_op("MULHSU -1*-1",   3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    run_op("DIV -7/2",       3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34);
    run_op("REM -7/2",       3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34);
    run_op("DIVU 100/7",     3'b101, 32'd100,        32'd7,         32'd14,        34);
    run_op("REMU 100/7",     3'b111, 32'd100,        32'd7,         32'd2,         34);
    run_op("DIV 5/0",        3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    run_op("REMU 5/0",       3'b111, 32'd5,          32'd0,         32'd5,         1);
    run_op("DIV ovf",        3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("REM ovf",        3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);
    run_op("REMU 100/7 again", 3'b111, 32'd100,      32'd7,         32'd2,         34);

    // Flush at cycle k+10 of a DIVU, with ignored start pulses while busy
    @(posedge clk); #1;
    f3 = 3'b101; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 2; i <= 10; i++) begin
      @(posedge clk); #1;
      start = (i == 4 || i == 7);
      f3 = 3'b000; a = 32'd9; b = 32'd9;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", {31'd0, busy}, 32'd0);
    check("flush result held", result, 32'd2);
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("flush no done", 32'(ndone), 32'd0);
    check("flush result still held", result, 32'd2);

    run_op("MUL 3*4", 3'b000, 32'd3, 32'd4, 32'd12, 34);

    // Reset in the middle of CALC
    @(posedge clk); #1;
    f3 = 3'b000; a = 32'd5; b = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    check("midrst result", result, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 499) == 0);
      f3    = 3'($urandom);
      a     = pick();
      b     = pick();
    end
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0; rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide unit for the EX stage.
- Accepts one R_TYPE/F7=0000001 operation at a time and runs a 32-cycle shift-add multiply or a 32-cycle restoring divide on operand magnitudes.
- Applies RISC-V sign and special-case rules, then presents the 32-bit result for one cycle.
- Drives `busy`, which the hazard logic ORs into the EX stall so that IF/ID/EX hold while an operation is in flight.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported and verified.
- CNT_W, 5, iteration counter width; must equal log2(WIDTH).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  launch request; sampled only in IDLE
- flush  in  1  abort current operation (branch/exception flush)
- f3  in  3  M-ext funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  in  WIDTH  rs1 operand (forwarded value)
- b  in  WIDTH  rs2 operand (forwarded value)
- busy  out  1  high in CALC and FIX states
- done  out  1  single-cycle pulse; result valid this cycle
- result  out  WIDTH  final result; holds its value until the next done

Behaviour:
- Reset:
  - Synchronous and active-high; takes priority over everything.
  - Sets state=IDLE, busy=0, done=0, result=0, counter=0, internal registers=0.
- States: IDLE, CALC, FIX, DONE.
- Latching in IDLE:
  - When start=1 and flush=0, latch f3, a, b.
  - Compute sign flags:
    - a_neg = a[31] for MULH, MULHSU, DIV, REM.
    - b_neg = b[31] for MULH, DIV, REM.
  - Latch |a| and |b| using the two's complement of the negative operands.
- Transitions from IDLE:
  - Divide/rem with b==0 → DONE. Result is 0xFFFFFFFF for DIV/DIVU; a for REM/REMU.
  - DIV/REM with a==0x80000000 and b==0xFFFFFFFF → DONE. Result is 0x80000000 for DIV, 0 for REM.
  - Otherwise → CALC, counter=0.
- CALC (32 cycles, one bit per cycle):
  - Multiply: 64-bit product accumulator, shift-add over the latched |b| bits, LSB first.
  - Divide: restoring, 33-bit partial remainder, quotient shifted in LSB.
  - Counter increments each cycle; when counter==31, go to FIX.
- FIX (1 cycle): negate and select.
  - Product negated if a_neg^b_neg.
  - MUL selects low 32 bits; MULH/MULHSU/MULHU select high 32 bits.
  - Quotient negated if a_neg^b_neg; remainder negated if a_neg.
  - Write the result register, then go to DONE.
- DONE (1 cycle): done=1, busy=0, then → IDLE.
- Latency (start high in cycle k):
  - Normal path: busy high in cycles k+1..k+33; done high in cycle k+34.
  - Special-case path: done high in cycle k+1; busy never asserts.
- Pipeline stall condition is (start & ~done) | busy. The stall is released in the done cycle so EX/MEM captures `result`.
- start while state≠IDLE: ignored, no queuing.
- flush:
  - In any state, returns to IDLE at the next edge with no done pulse; result keeps its old value.
  - flush and start in the same IDLE cycle: flush wins, no launch.
- Operand changes on a and b after the start cycle have no effect.
- Arithmetic is modulo 2^32 on the result. No flags are produced; ALU N/Z/C/V are not affected.

Test Plan:
- MUL a=7, b=0xFFFFFFFD → result=0xFFFFFFEB. done in cycle k+34; busy high k+1..k+33 only; done is a one-cycle pulse.
- High-word multiplies with a=b=0xFFFFFFFF, in three separate runs:
  - MULHU → 0xFFFFFFFE
  - MULH → 0x00000000
  - MULHSU → 0xFFFFFFFF
- Divide/remainder, each 34-cycle latency:
  - DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD
  - REM same operands → 0xFFFFFFFF
  - DIVU a=100, b=7 → 14
  - REMU a=100, b=7 → 2
- Special cases, each with done in cycle k+1 and busy never high:
  - DIV a=5, b=0 → 0xFFFFFFFF
  - REMU a=5, b=0 → 5
  - DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000
  - REM a=0x80000000, b=0xFFFFFFFF → 0
- Abort and ignore behaviour:
  - Start DIVU; assert flush in cycle k+10 → busy low from k+11, no done, result unchanged.
  - Start pulses during busy are ignored.
  - A new MUL 3×4 after the flush → 12 at its own k+34.
  - rst asserted mid-CALC → all outputs 0 the next cycle.
